vv_ctrl: RTL

Sequencer for the vector-vector multiply datapath (vector A / vector B operand memories, multiplier, optional accumulator, result RAM). On start it latches a job descriptor and issues operand read addresses. It tracks each element through the fixed read and multiply latency and produces write strobes/addresses aligned to the datapath output. Element-wise mode writes N products; dot mode drives accumulator clear/enable and writes one sum.

---
 rtl/vv_pkg.sv | 13 +
 rtl/vv_if.sv | 29 ++
 rtl/vv_valid_pipe.sv | 27 ++
 rtl/vv_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/vv_pkg.sv
// vv_pkg: shared types for the vector-vector multiply sequencer.
package vv_pkg;
    localparam int IDX_W = 8;
    localparam logic MODE_ELEM = 1'b0;
    localparam logic MODE_DOT = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef struct packed {
        logic valid;
        logic [IDX_W-1:0] idx;
        logic first;
        logic last;
    } pipe_entry_t;
endpackage

// File: rtl/vv_if.sv
// vv_if: job request / datapath control bundle between host and vv_ctrl.
interface vv_if #(
    parameter int AW = 5,
    parameter int LW = 3
);
    logic start;
    logic cfg_mode;
    logic [LW-1:0] cfg_len;
    logic [AW-1:0] cfg_a_base;
    logic [AW-1:0] cfg_b_base;
    logic [AW-1:0] cfg_dst_base;
    logic rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic acc_clr;
    logic acc_en;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic busy;
    logic done;
    modport master (
        output start, cfg_mode, cfg_len, cfg_a_base, cfg_b_base, cfg_dst_base,
        input rd_en, rd_addr_a, rd_addr_b, acc_clr, acc_en, wr_en, wr_addr, busy, done
    );
    modport slave (
        input start, cfg_mode, cfg_len, cfg_a_base, cfg_b_base, cfg_dst_base,
        output rd_en, rd_addr_a, rd_addr_b, acc_clr, acc_en, wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/vv_valid_pipe.sv
// vv_valid_pipe: shift register tracking element tags through read + multiply latency.
module vv_valid_pipe
    import vv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pipe_entry_t in_i,
    output pipe_entry_t out_o,
    output logic        empty_o
);
    pipe_entry_t stage_q [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (stage_q[i].valid) empty_o = 1'b0;
    end
    assign out_o = stage_q[DEPTH-1];
endmodule

// File: rtl/vv_ctrl.sv
// vv_ctrl: sequencer issuing operand reads and aligned accumulate/write strobes
// for element-wise or dot-product vector jobs.
module vv_ctrl
    import vv_pkg::*;
#(
    parameter int N = 4,
    parameter int BRAM_DEPTH = 32,
    parameter int AW = $clog2(BRAM_DEPTH),
    parameter int LW = $clog2(N + 1),
    parameter int RD_LAT = 1,
    parameter int MUL_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    vv_if.slave vv_io
);
    localparam int PIPE = RD_LAT + MUL_LAT;
    state_t state_q, state_d;
    logic mode_q;
    logic [LW-1:0] len_q, idx_q, eff_len, cur_len;
    logic [AW-1:0] a_q, b_q, dst_q;
    logic rd_en_q, acc_clr_q, acc_en_q, acc_last_q, wr_en_q, busy_q, done_q;
    logic [AW-1:0] rd_addr_a_q, rd_addr_b_q, wr_addr_q;
    pipe_entry_t ent_d, po;
    logic pipe_empty, elem, dot, wr_d;
    assign elem = mode_q == MODE_ELEM;
    assign dot = mode_q == MODE_DOT;
    assign wr_d = elem ? po.valid : acc_last_q;
    // Element 0 is issued on the start edge itself so reads begin the cycle after start.
    always_comb begin
        eff_len = (vv_io.cfg_len > LW'(N)) ? LW'(N) : vv_io.cfg_len;
        cur_len = (state_q == IDLE) ? eff_len : len_q;
        ent_d = '0;
        ent_d.valid = (state_q == IDLE && vv_io.start && eff_len != '0) ||
                      (state_q == ISSUE && idx_q != len_q);
        ent_d.idx = (state_q == IDLE) ? '0 : IDX_W'(idx_q);
        ent_d.first = ent_d.idx == '0;
        ent_d.last = ent_d.idx == IDX_W'(cur_len - LW'(1));
        state_d = state_q;
        case (state_q)
            IDLE:    if (vv_io.start) state_d = (eff_len == '0) ? DONE : ISSUE;
            ISSUE:   if (idx_q == len_q) state_d = DRAIN;
            DRAIN:   if (pipe_empty && !acc_last_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    vv_valid_pipe #(.DEPTH(PIPE)) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (ent_d),
        .out_o   (po),
        .empty_o (pipe_empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q <= 1'b0;
            len_q <= '0;
            idx_q <= '0;
            a_q <= '0;
            b_q <= '0;
            dst_q <= '0;
            rd_en_q <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            acc_clr_q <= 1'b0;
            acc_en_q <= 1'b0;
            acc_last_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q <= state_d == ISSUE || state_d == DRAIN;
            done_q <= state_d == DONE;
            rd_en_q <= ent_d.valid;
            if (ent_d.valid) begin
                rd_addr_a_q <= ((state_q == IDLE) ? vv_io.cfg_a_base : a_q) + AW'(ent_d.idx);
                rd_addr_b_q <= ((state_q == IDLE) ? vv_io.cfg_b_base : b_q) + AW'(ent_d.idx);
            end
            if (state_q == IDLE && vv_io.start) begin
                mode_q <= vv_io.cfg_mode;
                len_q <= eff_len;
                a_q <= vv_io.cfg_a_base;
                b_q <= vv_io.cfg_b_base;
                dst_q <= vv_io.cfg_dst_base;
                idx_q <= LW'(1);
            end else if (ent_d.valid) begin
                idx_q <= idx_q + LW'(1);
            end
            acc_en_q <= po.valid && dot;
            acc_clr_q <= po.valid && dot && po.first;
            // The sum is written one cycle after its last accumulate, once the accumulator register holds it.
            acc_last_q <= po.valid && dot && po.last;
            wr_en_q <= wr_d;
            if (wr_d) wr_addr_q <= dst_q + (elem ? AW'(po.idx) : '0);
        end
    end
    assign vv_io.rd_en = rd_en_q;
    assign vv_io.rd_addr_a = rd_addr_a_q;
    assign vv_io.rd_addr_b = rd_addr_b_q;
    assign vv_io.acc_clr = acc_clr_q;
    assign vv_io.acc_en = acc_en_q;
    assign vv_io.wr_en = wr_en_q;
    assign vv_io.wr_addr = wr_addr_q;
    assign vv_io.busy = busy_q;
    assign vv_io.done = done_q;
endmodule
